// File: rtl/mmio_timer_if.sv
// Register-bus interface for memory-mapped peripherals: separate read and write
// address channels, per-byte write enables, and combinational read data.
interface bus_if;
   logic [31:0] raddr;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ren;
   logic        wen;
   logic [3:0]  bytemask;

   modport slave  (input raddr, waddr, wdata, ren, wen, bytemask, output rdata);
   modport master (output raddr, waddr, wdata, ren, wen, bytemask, input rdata);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit timer: mtime counts prescaled ticks and raises a level
// interrupt while it is at or above mtimecmp.
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
   input  logic clk,
   input  logic rst_n,
   bus_if.slave bus,
   output logic irq
);

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        en;
   logic        ie;
   logic [7:0]  presc;
   logic [7:0]  psc;

   logic        rhit;
   logic        whit;
   logic        wr;
   logic [2:0]  roff;
   logic [2:0]  woff;
   logic        ctrl_wr;
   logic        mt_lo_wr;
   logic        mt_hi_wr;
   logic        cmp_lo_wr;
   logic        cmp_hi_wr;
   logic        tick;
   logic        cmp;
   logic [31:0] ctrl_rd;
   logic [31:0] ctrl_new;
   logic [31:0] rdata_c;
   logic        unused_bits;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [3:0]  mask);
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++)
         if (mask[i]) res[8*i +: 8] = wd[8*i +: 8];
      return res;
   endfunction

   assign rhit = (bus.raddr[31:5] == BASE_ADDR[31:5]);
   assign whit = (bus.waddr[31:5] == BASE_ADDR[31:5]);
   assign roff = bus.raddr[4:2];
   assign woff = bus.waddr[4:2];

   // An all-zero bytemask changes nothing, so it must not count as a CTRL write either.
   assign wr        = bus.wen && whit && (bus.bytemask != 4'b0000);
   assign ctrl_wr   = wr && (woff == 3'd4);
   assign mt_lo_wr  = wr && (woff == 3'd0);
   assign mt_hi_wr  = wr && (woff == 3'd1);
   assign cmp_lo_wr = wr && (woff == 3'd2);
   assign cmp_hi_wr = wr && (woff == 3'd3);

   assign ctrl_rd  = {16'h0000, presc, 6'b000000, ie, en};
   assign ctrl_new = merge_bytes(ctrl_rd, bus.wdata, bus.bytemask);
   assign cmp      = (mtime >= mtimecmp);
   assign tick     = en && (psc == presc) && !ctrl_wr;

   assign unused_bits = ^{bus.raddr[1:0], bus.waddr[1:0], ctrl_new[31:16], ctrl_new[7:2]};

   always_comb begin
      rdata_c = 32'h0;
      if (bus.ren && rhit) begin
         case (roff)
            3'd0:    rdata_c = mtime[31:0];
            3'd1:    rdata_c = mtime[63:32];
            3'd2:    rdata_c = mtimecmp[31:0];
            3'd3:    rdata_c = mtimecmp[63:32];
            3'd4:    rdata_c = ctrl_rd;
            3'd5:    rdata_c = {31'h0, cmp};
            default: rdata_c = 32'h0;
         endcase
      end
   end

   assign bus.rdata = rdata_c;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mtime    <= 64'h0;
         mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
         en       <= 1'b0;
         ie       <= 1'b0;
         presc    <= 8'h00;
         psc      <= 8'h00;
         irq      <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            en    <= ctrl_new[0];
            ie    <= ctrl_new[1];
            presc <= ctrl_new[15:8];
            psc   <= 8'h00;
         end else if (en) begin
            psc <= (psc == presc) ? 8'h00 : psc + 8'h01;
         end

         // A software write to either half wins over the tick for the whole counter.
         if (mt_lo_wr)
            mtime[31:0] <= merge_bytes(mtime[31:0], bus.wdata, bus.bytemask);
         else if (mt_hi_wr)
            mtime[63:32] <= merge_bytes(mtime[63:32], bus.wdata, bus.bytemask);
         else if (tick)
            mtime <= mtime + 64'h1;

         if (cmp_lo_wr)
            mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], bus.wdata, bus.bytemask);
         if (cmp_hi_wr)
            mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus.wdata, bus.bytemask);

         irq <= ie & cmp;
      end
   end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_2000, is the 32-byte-aligned base address of the register window.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port bus, bus_if.slave modport: raddr, waddr, wdata, ren, wen, bytemask are inputs; rdata is the output.
REQ-005 Port irq, output, 1 bit: registered timer interrupt, level-sensitive.

Function
REQ-006 Decode: an access hits when addr[31:5] == BASE_ADDR[31:5]; the offset is addr[4:2]; addr[1:0] are ignored.
REQ-007 Register map: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL, 5 STATUS; offsets 6-7 are unmapped.
REQ-008 CTRL bit0 = EN (count enable), bit1 = IE (irq enable), bits[15:8] = PRESC; all other CTRL bits read 0.
REQ-009 STATUS bit0 = CMP, defined as (mtime >= mtimecmp) unsigned 64-bit; STATUS is read-only and all other bits read 0.
REQ-010 Read: combinational, zero latency; when ren=1 and the access hits, rdata = the selected register's current (pre-edge) value.
REQ-011 rdata shall be 0 when ren=0, on a miss, or on an unmapped offset.
REQ-012 Write: when wen=1 and the access hits, each byte i with bytemask[i]=1 replaces byte i of the target register at the clock edge.
REQ-013 Bytes with bytemask[i]=0 shall be unchanged by a write.
REQ-014 Writes to STATUS, to unmapped offsets, or on a miss are ignored; bytemask=4'b0000 is a no-op write.
REQ-015 Simultaneous ren and wen (any addresses) are both serviced; a read returns the old value.
REQ-016 Prescaler: 8-bit counter psc; while EN=1, psc increments each cycle.
REQ-017 When psc == PRESC, psc wraps to 0 and mtime increments by 1 (a tick); PRESC=0 therefore gives a tick every cycle.
REQ-018 While EN=0, psc and mtime hold their values.
REQ-019 Any CTRL write clears psc to 0 in the same edge and suppresses the tick in that cycle.
REQ-020 mtime is 64-bit and wraps 0xFFFF_FFFF_FFFF_FFFF -> 0 with no flag; the carry from LO to HI applies within the same increment.
REQ-021 A write to MTIME_LO or MTIME_HI suppresses that cycle's increment: written bytes take wdata, all other bytes keep their old value, and psc is unaffected.
REQ-022 irq is registered: irq <= IE & CMP, evaluated on pre-edge register values, giving a 1-cycle latency from the condition to irq.
REQ-023 irq deasserts 1 cycle after CMP falls (mtimecmp raised, mtime lowered, or wrap) or after IE is cleared.

Reset
REQ-024 On an rst_n=0 edge: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, psc=0, irq=0.
REQ-025 Reset overrides any concurrent bus write or tick, including mid-count.
REQ-026 rdata depends only on the registers and inputs, so it reads reset values in the cycle after reset.

Verification
REQ-027 Reset: read every offset 0-7 -> 0, 0, FFFF_FFFF, FFFF_FFFF, 0, 0, 0, 0; irq=0.
REQ-028 Prescale: write CTRL=0x0000_0301 (PRESC=3, EN=1) -> mtime increments once every 4 cycles; after 40 cycles MTIME_LO = 10.
REQ-029 Carry/wrap:
- Write MTIME_LO=FFFF_FFFF with PRESC=0, EN=1 -> on the next tick LO=0 and HI=1.
- Set both halves to FFFF_FFFF -> on the next tick mtime=0.
REQ-030 Byte mask: MTIMECMP_LO=0x1122_3344, then write wdata=0xAABB_CCDD with bytemask=4'b0101 -> readback 0x11BB_33DD.
REQ-031 Irq:
- mtimecmp=20, CTRL=0x3 (IE=1, EN=1, PRESC=0), mtime from 0 -> STATUS.CMP=1 in the cycle mtime reads 20, and irq=1 one cycle later.
- Then write MTIMECMP_HI=1 -> irq=0 one cycle after that write.
REQ-032 Collisions:
- A write to MTIME_LO on a tick cycle -> the written value is read back with no +1.
- Unmapped offset 6, or BASE_ADDR+0x20: write -> no register changes; read -> 0.
- rst_n=0 asserted mid-count -> all registers return to reset values on the next edge.
